// File: rtl/board_port_arbiter.sv
// Port-1 arbiter for one board_mem: shares the control-side port between the
// board clear engine, main FSM cell accesses and a background ship-cell scanner.
module board_port_arbiter #(
    parameter int X_ADDR_WIDTH = 4,
    parameter int Y_ADDR_WIDTH = 4,
    parameter int X_SIZE       = 12,
    parameter int Y_SIZE       = 12,
    parameter int DATA_WIDTH   = 2,
    parameter logic [DATA_WIDTH-1:0] SHIP_CODE = 2'b01,
    parameter int MEM_RD_LAT   = 1,
    localparam int AW = X_ADDR_WIDTH + Y_ADDR_WIDTH,
    localparam int DW = DATA_WIDTH
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear_start,
    output logic          clear_busy,
    output logic          clear_done,
    input  logic          scan_en,
    input  logic          fsm_req,
    input  logic          fsm_w_nr,
    input  logic [AW-1:0] fsm_addr,
    input  logic [DW-1:0] fsm_wdata,
    output logic          fsm_gnt,
    output logic [DW-1:0] fsm_rdata,
    output logic          fsm_rvalid,
    output logic [AW-1:0] mem_addr,
    output logic          mem_w_nr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic [7:0]    ship_cnt,
    output logic          ship_cnt_vld
);

    localparam logic [X_ADDR_WIDTH-1:0] X_LAST = X_ADDR_WIDTH'(X_SIZE - 1);
    localparam logic [Y_ADDR_WIDTH-1:0] Y_LAST = Y_ADDR_WIDTH'(Y_SIZE - 1);

    typedef enum logic {
        IDLE,
        CLEAR
    } state_t;

    state_t state;

    logic [X_ADDR_WIDTH-1:0] clr_x;
    logic [Y_ADDR_WIDTH-1:0] clr_y;
    logic [X_ADDR_WIDTH-1:0] scan_x;
    logic [Y_ADDR_WIDTH-1:0] scan_y;
    logic [7:0]              acc;

    // One bit per cycle of read latency; stage MEM_RD_LAT lines up with mem_rdata.
    logic [MEM_RD_LAT:0] fsm_tag;
    logic [MEM_RD_LAT:0] scan_tag;
    logic [MEM_RD_LAT:0] last_tag;

    logic       clr_last;
    logic       scan_last;
    logic       scan_issue;
    logic       scan_hit;
    logic [7:0] acc_next;

    assign fsm_gnt    = fsm_req & ~clear_busy;
    assign scan_issue = (state == IDLE) & scan_en & ~fsm_gnt;
    assign clr_last   = (clr_x == X_LAST) && (clr_y == Y_LAST);
    assign scan_last  = (scan_x == X_LAST) && (scan_y == Y_LAST);
    assign scan_hit   = scan_tag[MEM_RD_LAT] && (mem_rdata == SHIP_CODE);
    assign acc_next   = acc + {7'd0, scan_hit};
    assign fsm_rvalid = fsm_tag[MEM_RD_LAT];
    assign fsm_rdata  = fsm_rvalid ? mem_rdata : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            clear_busy   <= 1'b0;
            clear_done   <= 1'b0;
            mem_addr     <= '0;
            mem_w_nr     <= 1'b0;
            mem_wdata    <= '0;
            ship_cnt     <= '0;
            ship_cnt_vld <= 1'b0;
            clr_x        <= '0;
            clr_y        <= '0;
            scan_x       <= '0;
            scan_y       <= '0;
            acc          <= '0;
            fsm_tag      <= '0;
            scan_tag     <= '0;
            last_tag     <= '0;
        end else begin
            clear_done   <= 1'b0;
            ship_cnt_vld <= 1'b0;
            mem_w_nr     <= 1'b0;

            fsm_tag[0]  <= fsm_gnt & ~fsm_w_nr;
            scan_tag[0] <= scan_issue;
            last_tag[0] <= scan_issue & scan_last;
            for (int i = 1; i <= MEM_RD_LAT; i++) begin
                fsm_tag[i]  <= fsm_tag[i-1];
                scan_tag[i] <= scan_tag[i-1];
                last_tag[i] <= last_tag[i-1];
            end

            case (state)
                IDLE: begin
                    if (fsm_gnt) begin
                        mem_addr  <= fsm_addr;
                        mem_w_nr  <= fsm_w_nr;
                        mem_wdata <= fsm_wdata;
                    end else if (scan_issue) begin
                        mem_addr <= {scan_y, scan_x};
                        if (scan_x == X_LAST) begin
                            scan_x <= '0;
                            scan_y <= (scan_y == Y_LAST) ? '0 : scan_y + 1'b1;
                        end else begin
                            scan_x <= scan_x + 1'b1;
                        end
                    end

                    if (scan_tag[MEM_RD_LAT]) begin
                        if (last_tag[MEM_RD_LAT]) begin
                            ship_cnt     <= acc_next;
                            ship_cnt_vld <= 1'b1;
                            acc          <= '0;
                        end else begin
                            acc <= acc_next;
                        end
                    end

                    // Scan reads still in flight are stale once the board is wiped.
                    if (clear_start) begin
                        state      <= CLEAR;
                        clear_busy <= 1'b1;
                        clr_x      <= '0;
                        clr_y      <= '0;
                        scan_tag   <= '0;
                        last_tag   <= '0;
                    end
                end

                CLEAR: begin
                    mem_addr  <= {clr_y, clr_x};
                    mem_w_nr  <= 1'b1;
                    mem_wdata <= '0;
                    if (clr_x == X_LAST) begin
                        clr_x <= '0;
                        clr_y <= clr_y + 1'b1;
                    end else begin
                        clr_x <= clr_x + 1'b1;
                    end
                    if (clr_last) begin
                        state      <= IDLE;
                        clear_busy <= 1'b0;
                        clear_done <= 1'b1;
                        clr_x      <= '0;
                        clr_y      <= '0;
                        scan_x     <= '0;
                        scan_y     <= '0;
                        acc        <= '0;
                    end
                end

                default: begin
                    state      <= IDLE;
                    clear_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_board_port_arbiter.sv
// Self-checking bench for board_port_arbiter with a 1-cycle-latency board memory
// model, a shadow copy of the expected board, and read / ship-count scoreboards.
module tb_board_port_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       clear_start;
    logic       clear_busy;
    logic       clear_done;
    logic       scan_en;
    logic       fsm_req;
    logic       fsm_w_nr;
    logic [7:0] fsm_addr;
    logic [1:0] fsm_wdata;
    logic       fsm_gnt;
    logic [1:0] fsm_rdata;
    logic       fsm_rvalid;
    logic [7:0] mem_addr;
    logic       mem_w_nr;
    logic [1:0] mem_wdata;
    logic [1:0] mem_rdata;
    logic [7:0] ship_cnt;
    logic       ship_cnt_vld;

    board_port_arbiter dut (
        .clk          (clk),
        .rst          (rst),
        .clear_start  (clear_start),
        .clear_busy   (clear_busy),
        .clear_done   (clear_done),
        .scan_en      (scan_en),
        .fsm_req      (fsm_req),
        .fsm_w_nr     (fsm_w_nr),
        .fsm_addr     (fsm_addr),
        .fsm_wdata    (fsm_wdata),
        .fsm_gnt      (fsm_gnt),
        .fsm_rdata    (fsm_rdata),
        .fsm_rvalid   (fsm_rvalid),
        .mem_addr     (mem_addr),
        .mem_w_nr     (mem_w_nr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .ship_cnt     (ship_cnt),
        .ship_cnt_vld (ship_cnt_vld)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       w;
        logic [7:0] addr;
        logic [1:0] wdata;
        logic [1:0] exp;
    } vec_t;

    typedef struct {
        int data;
        int cyc;
    } rd_t;

    logic [1:0] mem [256];
    logic [1:0] shadow [256];
    rd_t        rd_q[$];
    int         exp_ship[$];
    int         ship_cycles[$];

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int clr_idx = 0;
    bit clr_mon = 1'b0;
    int busy_cycles = 0;
    int done_pulses = 0;
    int total_writes = 0;

    always @(posedge clk) begin
        if (mem_w_nr) mem[mem_addr] <= mem_wdata;
        mem_rdata <= mem[mem_addr];
        cyc <= cyc + 1;
    end

    task automatic check(input string name, input int actual, input int expected);
        tests++;
        if (actual != expected) begin
            fails++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one FSM access, waits (bounded) for the grant and books the expectation.
    task automatic fsm_access(input logic w, input logic [7:0] a, input logic [1:0] d,
                              input logic [1:0] exp);
        int k = 0;
        fsm_req   = 1'b1;
        fsm_w_nr  = w;
        fsm_addr  = a;
        fsm_wdata = d;
        #1;
        while (!fsm_gnt && k < 400) begin
            @(posedge clk);
            #2;
            k++;
        end
        check("fsm_gnt", int'(fsm_gnt), 1);
        if (fsm_gnt) begin
            if (w) shadow[a] = d;
            else   rd_q.push_back('{data: int'(exp), cyc: cyc});
        end
        @(posedge clk);
        #1;
        fsm_req = 1'b0;
    endtask

    function automatic int shadow_ships();
        int n = 0;
        for (int y = 0; y < 12; y++)
            for (int x = 0; x < 12; x++)
                if (shadow[y*16+x] == 2'b01) n++;
        return n;
    endfunction

    task automatic clear_shadow();
        for (int i = 0; i < 256; i++) shadow[i] = 2'b00;
    endtask

    // Full clear; with hold_fsm an FSM write coincides with clear_start and a read stays pending.
    task automatic clear_and_check(input bit hold_fsm);
        int k;
        int gnt_busy = 0;
        busy_cycles = 0;
        done_pulses = 0;
        clr_idx     = 0;
        clear_start = 1'b1;
        if (hold_fsm) begin
            fsm_req   = 1'b1;
            fsm_w_nr  = 1'b1;
            fsm_addr  = 8'h77;
            fsm_wdata = 2'b01;
            #1;
            check("gnt_with_clear_start", int'(fsm_gnt), 1);
        end
        tick();
        clear_start = 1'b0;
        fsm_w_nr    = 1'b0;
        clear_shadow();
        k = 1;
        while (clear_busy && k < 300) begin
            #1;
            if (fsm_gnt) gnt_busy++;
            tick();
            k++;
            if (k == 2) clr_mon = 1'b1;
        end
        check("clear_busy_falls", int'(clear_busy), 0);
        if (hold_fsm) begin
            #1;
            check("gnt_after_clear", int'(fsm_gnt), 1);
            if (fsm_gnt) rd_q.push_back('{data: 0, cyc: cyc});
            tick();
            fsm_req = 1'b0;
            check("gnt_during_clear", gnt_busy, 0);
        end
        repeat (4) tick();
        check("clear_busy_cycles", busy_cycles, 144);
        check("clear_write_count", clr_idx, 144);
        check("clear_done_pulses", done_pulses, 1);
        check("clear_mon_closed", int'(clr_mon), 0);
        clr_mon = 1'b0;
    endtask

    // Output monitor: read-data scoreboard, ship scoreboard and clear-write order.
    initial begin
        rd_t e;
        int  exp_addr;
        forever begin
            @(negedge clk);
            if (clear_busy) busy_cycles++;
            if (clear_done) done_pulses++;
            if (mem_w_nr) total_writes++;
            if (mem_w_nr && clr_mon) begin
                exp_addr = (clr_idx / 12) * 16 + (clr_idx % 12);
                check("clear_addr", int'(mem_addr), exp_addr);
                check("clear_wdata", int'(mem_wdata), 0);
                clr_idx++;
            end
            if (clear_done) clr_mon = 1'b0;
            if (fsm_rvalid) begin
                if (rd_q.size() == 0) begin
                    check("rvalid_unexpected", int'(fsm_rvalid), 0);
                end else begin
                    e = rd_q.pop_front();
                    check("fsm_rdata", int'(fsm_rdata), e.data);
                    check("rvalid_latency", cyc - e.cyc, 2);
                end
            end
            if (ship_cnt_vld) begin
                ship_cycles.push_back(cyc);
                if (exp_ship.size() == 0) check("ship_vld_unexpected", int'(ship_cnt_vld), 0);
                else                      check("ship_cnt", int'(ship_cnt), exp_ship.pop_front());
            end
        end
    end

    vec_t rw_vecs[11];
    vec_t pre_vecs[5];
    vec_t post_vecs[5];

    initial begin
        int k;
        int per;
        int wr_snap;
        logic [7:0] a;

        rw_vecs = '{
            '{1'b1, 8'h35, 2'b01, 2'b00}, '{1'b0, 8'h35, 2'b00, 2'b01},
            '{1'b1, 8'h00, 2'b10, 2'b00}, '{1'b1, 8'hBB, 2'b11, 2'b00},
            '{1'b0, 8'h00, 2'b00, 2'b10}, '{1'b0, 8'hBB, 2'b00, 2'b11},
            '{1'b0, 8'h36, 2'b00, 2'b00}, '{1'b1, 8'h35, 2'b00, 2'b00},
            '{1'b0, 8'h35, 2'b00, 2'b00}, '{1'b0, 8'h0B, 2'b00, 2'b00},
            '{1'b0, 8'hB0, 2'b00, 2'b00}
        };
        pre_vecs = '{
            '{1'b1, 8'h40, 2'b10, 2'b00}, '{1'b1, 8'h41, 2'b11, 2'b00},
            '{1'b1, 8'h42, 2'b01, 2'b00}, '{1'b1, 8'h43, 2'b10, 2'b00},
            '{1'b1, 8'hBB, 2'b11, 2'b00}
        };
        post_vecs = '{
            '{1'b0, 8'h40, 2'b00, 2'b00}, '{1'b0, 8'h41, 2'b00, 2'b00},
            '{1'b0, 8'h42, 2'b00, 2'b01}, '{1'b0, 8'h43, 2'b00, 2'b10},
            '{1'b0, 8'hBB, 2'b00, 2'b11}
        };

        rst = 1'b1; clear_start = 1'b0; scan_en = 1'b0;
        fsm_req = 1'b0; fsm_w_nr = 1'b0; fsm_addr = 8'h00; fsm_wdata = 2'b00;
        clear_shadow();
        repeat (3) tick();
        check("rst_clear_busy", int'(clear_busy), 0);
        check("rst_clear_done", int'(clear_done), 0);
        check("rst_mem_w_nr", int'(mem_w_nr), 0);
        check("rst_mem_addr", int'(mem_addr), 0);
        check("rst_fsm_rvalid", int'(fsm_rvalid), 0);
        check("rst_ship_cnt", int'(ship_cnt), 0);
        check("rst_ship_vld", int'(ship_cnt_vld), 0);
        rst = 1'b0;
        tick();

        $display("[TB] clear after reset");
        clear_and_check(1'b0);

        $display("[TB] table-driven FSM accesses");
        for (int i = 0; i < 11; i++)
            fsm_access(rw_vecs[i].w, rw_vecs[i].addr, rw_vecs[i].wdata, rw_vecs[i].exp);
        repeat (4) tick();
        check("rd_queue_drained_t2", rd_q.size(), 0);

        $display("[TB] scan with 17 ship cells");
        for (int i = 0; i < 16; i++) begin
            k = (i * 31) % 144;
            a = 8'((k / 12) * 16 + (k % 12));
            fsm_access(1'b1, a, 2'b01, 2'b00);
        end
        fsm_access(1'b1, 8'hBB, 2'b01, 2'b00);
        check("shadow_ship_model", shadow_ships(), 17);
        ship_cycles.delete();
        exp_ship.push_back(shadow_ships());
        exp_ship.push_back(shadow_ships());
        scan_en = 1'b1;
        k = 0;
        while (ship_cycles.size() < 2 && k < 700) begin
            tick();
            k++;
        end
        scan_en = 1'b0;
        repeat (5) tick();
        check("ship_pulses_t3", ship_cycles.size(), 2);
        per = (ship_cycles.size() >= 2) ? ship_cycles[1] - ship_cycles[0] : -1;
        check("ship_period_free", per, 144);

        $display("[TB] scan interleaved with FSM reads");
        ship_cycles.delete();
        exp_ship.push_back(shadow_ships());
        exp_ship.push_back(shadow_ships());
        scan_en = 1'b1;
        k = 0;
        while (ship_cycles.size() < 2 && k < 1400) begin
            if (k % 2 == 0) begin
                a = {4'($urandom_range(0, 11)), 4'($urandom_range(0, 11))};
                fsm_access(1'b0, a, 2'b00, shadow[a]);
            end else begin
                tick();
            end
            k++;
        end
        scan_en = 1'b0;
        repeat (5) tick();
        check("ship_pulses_t4", ship_cycles.size(), 2);
        per = (ship_cycles.size() >= 2) ? ship_cycles[1] - ship_cycles[0] : -1;
        check("ship_period_shared", per, 288);
        check("exp_ship_drained", exp_ship.size(), 0);

        $display("[TB] clear racing an FSM request");
        clear_and_check(1'b1);
        repeat (3) tick();
        check("rd_queue_drained_t5", rd_q.size(), 0);

        $display("[TB] reset in the middle of a clear");
        for (int i = 0; i < 5; i++)
            fsm_access(pre_vecs[i].w, pre_vecs[i].addr, pre_vecs[i].wdata, pre_vecs[i].exp);
        done_pulses = 0;
        clr_idx     = 0;
        clear_start = 1'b1;
        tick();
        clear_start = 1'b0;
        tick();
        clr_mon = 1'b1;
        k = 0;
        while (clr_idx < 50 && k < 300) begin
            @(negedge clk);
            #1;
            k++;
        end
        check("writes_before_rst", clr_idx, 50);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_clear_busy", int'(clear_busy), 0);
        check("midrst_mem_w_nr", int'(mem_w_nr), 0);
        check("midrst_mem_addr", int'(mem_addr), 0);
        check("midrst_clear_done", int'(clear_done), 0);
        check("midrst_ship_cnt", int'(ship_cnt), 0);
        tick();
        rst = 1'b0;
        wr_snap = total_writes;
        repeat (20) tick();
        check("writes_after_rst", total_writes - wr_snap, 0);
        check("clear_idx_after_rst", clr_idx, 50);
        check("done_after_rst", done_pulses, 0);
        clr_mon = 1'b0;
        for (int i = 0; i < 5; i++)
            fsm_access(post_vecs[i].w, post_vecs[i].addr, post_vecs[i].wdata, post_vecs[i].exp);
        repeat (4) tick();
        check("rd_queue_drained_t6", rd_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
